// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        REQUEST      = 2'b01,
        WAIT_RELEASE = 2'b10
    } state_t;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int STATUS_ID_LSB    = 0;
    localparam int STATUS_STATE_LSB = 4;
    localparam int STATUS_ACK_ERROR = 6;

    // Source registers never exceed 16 bits, so only lanes 0 and 1 matter.
    function automatic logic [15:0] lane_mask(input logic [3:0] bwe);
        return {{8{bwe[1]}}, {8{bwe[0]}}};
    endfunction

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Lowest-index-first 16-to-4 priority encoder with an any-valid flag.
module interrupt_priority_encoder (
    input  logic [15:0] requests,
    output logic [3:0]  id,
    output logic        valid
);

    // Scan from the top so the lowest set index is the last assignment.
    always_comb begin
        id    = 4'd0;
        valid = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (requests[i]) begin
                id    = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: source sampling, pending/mask/mode registers,
// fixed-priority selection and request/acknowledge handshake to the core.
//
// state        | meaning
// IDLE         | no request outstanding; latch winner when any source eligible
// REQUEST      | interruptRequest high with latched id, waiting for acknowledge
// WAIT_RELEASE | acknowledge seen, waiting for the core to drop it
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int SOURCES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SOURCES-1:0] irqSource,
    input  logic               regRead,
    input  logic               regWrite,
    input  logic [1:0]         regAddress,
    input  logic [3:0]         regBwe,
    input  logic [31:0]        regDataIn,
    output logic [31:0]        regDataOut,
    output logic               regReadValid,
    output logic               regWaitRequest,
    output logic               interruptRequest,
    output logic [3:0]         interruptId,
    input  logic               interruptAcknowledge,
    input  logic [3:0]         interruptAckId
);

    state_t             state;
    logic [3:0]         id_reg;
    logic               ack_error;
    logic [SOURCES-1:0] source_reg, sticky, mask, mode;
    logic [SOURCES-1:0] pending, eligible, wmask, din;
    logic [SOURCES-1:0] mask_next, mode_next, clr, set, ack_bit;
    logic [15:0]        lanes, elig16;
    logic [3:0]         win_id;
    logic               win_valid;
    logic               wr_pending, wr_mask, wr_mode, wr_status;
    logic               ack_ok, ack_bad, clr_err;
    logic [31:0]        rdata;
    logic               unused_bits;

    assign unused_bits = ^{regDataIn, regBwe[3:2]};

    assign lanes = lane_mask(regBwe);
    assign wmask = lanes[SOURCES-1:0];
    assign din   = regDataIn[SOURCES-1:0];

    assign wr_pending = regWrite && (regAddress == REG_PENDING);
    assign wr_mask    = regWrite && (regAddress == REG_MASK);
    assign wr_mode    = regWrite && (regAddress == REG_MODE);
    assign wr_status  = regWrite && (regAddress == REG_STATUS);
    assign clr_err    = wr_status && regBwe[0] && regDataIn[STATUS_ACK_ERROR];

    assign ack_ok  = (state == REQUEST) && interruptAcknowledge && (interruptAckId == id_reg);
    assign ack_bad = (state == REQUEST) && interruptAcknowledge && (interruptAckId != id_reg);
    assign ack_bit = SOURCES'(1) << id_reg;

    // Edge-mode bits read the sticky latch, level-mode bits follow the sampled line.
    assign pending  = (sticky & mode) | (source_reg & ~mode);
    assign eligible = pending & mask;

    // Next-state values for the configuration registers and sticky set/clear vectors.
    always_comb begin
        mask_next = mask;
        mode_next = mode;
        if (wr_mask) mask_next = (mask & ~wmask) | (din & wmask);
        if (wr_mode) mode_next = (mode & ~wmask) | (din & wmask);
        clr = '0;
        if (wr_pending) clr = din & wmask;
        if (ack_ok)     clr = clr | ack_bit;
        set = irqSource & ~source_reg & mode_next;
    end

    // Pad to the encoder's fixed 16-bit width.
    always_comb begin
        elig16 = '0;
        elig16[SOURCES-1:0] = eligible;
    end

    interrupt_priority_encoder u_prio (
        .requests (elig16),
        .id       (win_id),
        .valid    (win_valid)
    );

    // Source sampling and register file; set beats clear, and leaving edge mode drops sticky state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            source_reg <= '0;
            sticky     <= '0;
            mask       <= '0;
            mode       <= '0;
            ack_error  <= 1'b0;
        end else begin
            source_reg <= irqSource;
            sticky     <= ((sticky & ~clr) | set) & mode_next;
            mask       <= mask_next;
            mode       <= mode_next;
            ack_error  <= ack_bad | (ack_error & ~clr_err);
        end
    end

    // Handshake FSM; the id and request are held untouched for the whole REQUEST state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            id_reg           <= 4'd0;
            interruptRequest <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        id_reg           <= win_id;
                        interruptRequest <= 1'b1;
                        state            <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (interruptAcknowledge) begin
                        interruptRequest <= 1'b0;
                        state            <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!interruptAcknowledge) state <= IDLE;
                end
                default: begin
                    interruptRequest <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

    assign interruptId    = id_reg;
    assign regWaitRequest = 1'b0;

    // Read data selection.
    always_comb begin
        rdata = '0;
        case (regAddress)
            REG_PENDING: rdata[SOURCES-1:0] = pending;
            REG_MASK:    rdata[SOURCES-1:0] = mask;
            REG_MODE:    rdata[SOURCES-1:0] = mode;
            default: begin
                rdata[STATUS_ID_LSB +: 4]    = id_reg;
                rdata[STATUS_STATE_LSB +: 2] = state;
                rdata[STATUS_ACK_ERROR]      = ack_error;
            end
        endcase
    end

    // Registered read port: data captured on the strobe edge and held until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regDataOut   <= '0;
            regReadValid <= 1'b0;
        end else begin
            regReadValid <= regRead;
            if (regRead) regDataOut <= rdata;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with an expected-value queue.
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] irqSource = '0;
    logic        regRead = 1'b0, regWrite = 1'b0;
    logic [1:0]  regAddress = '0;
    logic [3:0]  regBwe = '0;
    logic [31:0] regDataIn = '0;
    logic [31:0] regDataOut;
    logic        regReadValid, regWaitRequest, interruptRequest;
    logic [3:0]  interruptId;
    logic        interruptAcknowledge = 1'b0;
    logic [3:0]  interruptAckId = '0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interrupt_controller #(.SOURCES(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .irqSource            (irqSource),
        .regRead              (regRead),
        .regWrite             (regWrite),
        .regAddress           (regAddress),
        .regBwe               (regBwe),
        .regDataIn            (regDataIn),
        .regDataOut           (regDataOut),
        .regReadValid         (regReadValid),
        .regWaitRequest       (regWaitRequest),
        .interruptRequest     (interruptRequest),
        .interruptId          (interruptId),
        .interruptAcknowledge (interruptAcknowledge),
        .interruptAckId       (interruptAckId)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=0x%0h expected=queued value", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        regWrite = 1'b1; regAddress = a; regDataIn = d; regBwe = be;
        step();
        regWrite = 1'b0; regBwe = '0;
    endtask

    // Caller pushes the expected data before calling.
    task automatic rd(input logic [1:0] a);
        regRead = 1'b1; regAddress = a;
        step();
        regRead = 1'b0;
        sb_check(regDataOut);
        sb_push("read_valid", 32'd1);
        sb_check(32'(regReadValid));
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [3:0] id);
        sb_push({tag, "_req"}, 32'(r));
        sb_check(32'(interruptRequest));
        if (r) begin
            sb_push({tag, "_id"}, 32'(id));
            sb_check(32'(interruptId));
        end
    endtask

    task automatic ack(input logic [3:0] id);
        interruptAcknowledge = 1'b1; interruptAckId = id;
        step();
    endtask

    task automatic release_ack();
        interruptAcknowledge = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        step(); step();
        sb_push("rst_req", 0);   sb_check(32'(interruptRequest));
        sb_push("rst_id", 0);    sb_check(32'(interruptId));
        sb_push("rst_rdata", 0); sb_check(regDataOut);
        sb_push("rst_rvalid", 0); sb_check(32'(regReadValid));
        sb_push("rst_wait", 0);  sb_check(32'(regWaitRequest));
        reset = 1'b0;
        step();
        sb_push("rst_status", 0); rd(REG_STATUS);
        sb_push("rvalid_drop", 0); step(); sb_check(32'(regReadValid));

        // Edge source 3, one-cycle pulse, two-cycle latency
        wr(REG_MASK, 32'h8, 4'hF);
        wr(REG_MODE, 32'h8, 4'hF);
        irqSource = 16'h0008;
        step();
        irqSource = '0;
        chk_req("t1_e0", 1'b0, 4'd0);
        step();
        chk_req("t1_e1", 1'b1, 4'd3);
        sb_push("t1_pend", 32'h8);     rd(REG_PENDING);
        sb_push("t1_stat_req", 32'h13); rd(REG_STATUS);
        ack(4'd3);
        chk_req("t1_ack", 1'b0, 4'd0);
        sb_push("t1_pend_clr", 32'h0); rd(REG_PENDING);
        sb_push("t1_stat_wr", 32'h23); rd(REG_STATUS);
        release_ack();
        sb_push("t1_stat_idle", 32'h03); rd(REG_STATUS);

        // Sources 5 and 2 together: 2 first, one idle cycle, then 5
        wr(REG_MASK, 32'h24, 4'hF);
        wr(REG_MODE, 32'h24, 4'hF);
        irqSource = 16'h0024;
        step();
        irqSource = '0;
        step();
        chk_req("t2_first", 1'b1, 4'd2);
        ack(4'd2);
        chk_req("t2_ack2", 1'b0, 4'd0);
        release_ack();
        chk_req("t2_idle", 1'b0, 4'd0);
        step();
        chk_req("t2_second", 1'b1, 4'd5);
        ack(4'd5);
        release_ack();
        sb_push("t2_pend", 32'h0); rd(REG_PENDING);

        // Level source 7 masked off during REQUEST
        wr(REG_MODE, 32'h0, 4'hF);
        wr(REG_MASK, 32'h80, 4'hF);
        irqSource = 16'h0080;
        step();
        chk_req("t3_e0", 1'b0, 4'd0);
        step();
        chk_req("t3_e1", 1'b1, 4'd7);
        wr(REG_MASK, 32'h0, 4'hF);
        chk_req("t3_masked", 1'b1, 4'd7);
        step();
        chk_req("t3_hold", 1'b1, 4'd7);
        ack(4'd7);
        release_ack();
        step();
        chk_req("t3_norereq_a", 1'b0, 4'd0);
        step();
        chk_req("t3_norereq_b", 1'b0, 4'd0);
        sb_push("t3_level_pend", 32'h80); rd(REG_PENDING);
        irqSource = '0;

        // Mismatched acknowledge sets ackError and keeps pending
        wr(REG_MASK, 32'h2, 4'hF);
        wr(REG_MODE, 32'h2, 4'hF);
        irqSource = 16'h0002;
        step();
        irqSource = '0;
        step();
        chk_req("t4_req", 1'b1, 4'd1);
        ack(4'd4);
        chk_req("t4_badack", 1'b0, 4'd0);
        sb_push("t4_stat_err", 32'h61); rd(REG_STATUS);
        sb_push("t4_pend_kept", 32'h2); rd(REG_PENDING);
        release_ack();
        step();
        chk_req("t4_rereq", 1'b1, 4'd1);
        ack(4'd1);
        release_ack();
        wr(REG_STATUS, 32'h40, 4'h1);
        sb_push("t4_err_clr", 32'h01); rd(REG_STATUS);

        // W1C colliding with a new rising edge: set wins
        wr(REG_MASK, 32'h0, 4'hF);
        wr(REG_MODE, 32'h1, 4'hF);
        irqSource = 16'h0001;
        wr(REG_PENDING, 32'h1, 4'hF);
        irqSource = '0;
        sb_push("t5_set_wins", 32'h1); rd(REG_PENDING);
        wr(REG_PENDING, 32'h1, 4'hF);
        sb_push("t5_w1c", 32'h0); rd(REG_PENDING);

        // Byte lanes and bits above SOURCES
        wr(REG_MASK, 32'h0000FFFF, 4'b0010);
        sb_push("lane1_only", 32'hFF00); rd(REG_MASK);
        wr(REG_MASK, 32'hFFFF0000, 4'hF);
        sb_push("upper_ignored", 32'h0); rd(REG_MASK);

        // Reset during REQUEST drops outputs without a clock edge
        wr(REG_MASK, 32'h1, 4'hF);
        irqSource = 16'h0001;
        step();
        irqSource = '0;
        step();
        chk_req("t6_req", 1'b1, 4'd0);
        #2 reset = 1'b1;
        #1;
        sb_push("t6_async_req", 0); sb_check(32'(interruptRequest));
        sb_push("t6_async_rdata", 0); sb_check(regDataOut);
        step();
        reset = 1'b0;
        sb_push("t6_mask", 0);    rd(REG_MASK);
        sb_push("t6_mode", 0);    rd(REG_MODE);
        sb_push("t6_pending", 0); rd(REG_PENDING);
        sb_push("t6_status", 0);  rd(REG_STATUS);
        step();
        chk_req("t6_after", 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
